// File: rtl/lift_req_sched.sv
// Lift call scheduler. Calls collect in a pending bitmap. Targets are chosen
// with a SCAN sweep and drive the lift controller's req_floor input.
module lift_req_sched #(
    parameter int NUM_FLOORS = 16,
    parameter int DWELL      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [6:0]            call_floor,
    input  logic [6:0]            cur_floor,
    input  logic                  stop,
    output logic [6:0]            req_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  idle,
    output logic                  arrived,
    output logic                  call_accept,
    output logic                  call_reject
);

    localparam int CW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DWELL} state_t;

    state_t                  state_q;
    logic [6:0]              req_floor_q;
    logic [NUM_FLOORS-1:0]   pending_q;
    logic                    dir_up_q;
    logic                    arrived_q;
    logic                    call_accept_q;
    logic                    call_reject_q;
    logic [CW-1:0]           dwell_q;

    logic                    call_legal;
    logic                    reopen;
    logic [NUM_FLOORS-1:0]   set_vec;
    logic [NUM_FLOORS-1:0]   cur_oh;
    logic [NUM_FLOORS-1:0]   req_oh;
    logic [NUM_FLOORS-1:0]   above;
    logic [NUM_FLOORS-1:0]   below;
    logic [NUM_FLOORS-1:0]   pending_d;
    logic                    cur_pending;
    logic                    up_found;
    logic                    dn_found;
    logic [6:0]              up_floor;
    logic [6:0]              dn_floor;
    logic [6:0]              sel_floor_d;
    logic                    sel_dir_d;

    assign call_legal = call_valid && ({1'b0, call_floor} < 8'(NUM_FLOORS));
    // A call to the floor whose doors are open reopens them instead of queueing.
    assign reopen     = call_legal && (state_q == S_DWELL) && (call_floor == cur_floor);

    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
        assign set_vec[gi] = call_legal && !reopen && (call_floor == 7'(gi));
        assign cur_oh[gi]  = (cur_floor == 7'(gi));
        assign req_oh[gi]  = (req_floor_q == 7'(gi));
        assign above[gi]   = pending_q[gi] && (7'(gi) > cur_floor);
        assign below[gi]   = pending_q[gi] && (7'(gi) < cur_floor);
    end

    assign pending_d   = pending_q | set_vec;
    assign cur_pending = |(pending_q & cur_oh);

    // Nearest pending floor above and below the cab.
    always_comb begin
        up_found = 1'b0;
        up_floor = 7'd0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (above[f]) begin
                up_found = 1'b1;
                up_floor = 7'(f);
            end
        end
        dn_found = 1'b0;
        dn_floor = 7'd0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (below[f]) begin
                dn_found = 1'b1;
                dn_floor = 7'(f);
            end
        end
    end

    always_comb begin
        sel_floor_d = cur_floor;
        sel_dir_d   = dir_up_q;
        if (dir_up_q) begin
            if (up_found) begin
                sel_floor_d = up_floor;
            end else if (dn_found) begin
                sel_floor_d = dn_floor;
                sel_dir_d   = 1'b0;
            end
        end else begin
            if (dn_found) begin
                sel_floor_d = dn_floor;
            end else if (up_found) begin
                sel_floor_d = up_floor;
                sel_dir_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            req_floor_q   <= 7'd0;
            pending_q     <= '0;
            dir_up_q      <= 1'b1;
            arrived_q     <= 1'b0;
            call_accept_q <= 1'b0;
            call_reject_q <= 1'b0;
            dwell_q       <= '0;
        end else begin
            call_accept_q <= call_legal;
            call_reject_q <= call_valid && !call_legal;
            arrived_q     <= 1'b0;
            pending_q     <= pending_d;
            case (state_q)
                S_IDLE: begin
                    if (cur_pending && stop) begin
                        pending_q <= pending_d & ~cur_oh;
                        arrived_q <= 1'b1;
                        dwell_q   <= CW'(DWELL);
                        state_q   <= S_DWELL;
                    end else if (|pending_q) begin
                        req_floor_q <= sel_floor_d;
                        dir_up_q    <= sel_dir_d;
                        state_q     <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    // Clearing after the set lets an arrival swallow a same-floor call.
                    if ((cur_floor == req_floor_q) && stop) begin
                        pending_q <= pending_d & ~req_oh;
                        arrived_q <= 1'b1;
                        dwell_q   <= CW'(DWELL);
                        state_q   <= S_DWELL;
                    end else if ((req_floor_q > cur_floor) && up_found && (up_floor < req_floor_q)) begin
                        req_floor_q <= up_floor;
                    end else if ((req_floor_q < cur_floor) && dn_found && (dn_floor > req_floor_q)) begin
                        req_floor_q <= dn_floor;
                    end
                end
                S_DWELL: begin
                    if (reopen) begin
                        dwell_q <= CW'(DWELL);
                    end else if (dwell_q <= CW'(1)) begin
                        dwell_q <= '0;
                        if (|pending_q) begin
                            req_floor_q <= sel_floor_d;
                            dir_up_q    <= sel_dir_d;
                            state_q     <= S_MOVE;
                        end else begin
                            req_floor_q <= cur_floor;
                            state_q     <= S_IDLE;
                        end
                    end else begin
                        dwell_q <= dwell_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_floor   = req_floor_q;
    assign pending     = pending_q;
    assign dir_up      = dir_up_q;
    assign idle        = (state_q == S_IDLE);
    assign arrived     = arrived_q;
    assign call_accept = call_accept_q;
    assign call_reject = call_reject_q;

endmodule
